// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, data width and bit-timing helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY receive state).
package uart_pkg;

  localparam int unsigned DataWidth = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;
`endif

  // Clock cycles per line bit, integer division.
  function automatic int unsigned ticks_per_bit(input int unsigned clock_hz,
                                                input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line, resets to idle-high.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rx_sync
);

  logic meta;

  // Two-stage capture; both stages reset to the idle line level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx;
      rx_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, mid-bit sampling, LSB first.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit + parityError port).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned BaudRate       = 9600
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DataWidth-1:0] data,
  output logic                 valid,
  output logic                 frameError,
`ifdef UART_RX_PARITY_EN
  output logic                 parityError,
`endif
  output logic                 busy
);

  localparam int unsigned BitTicks  = ticks_per_bit(ClockFrequency, BaudRate);
  localparam int unsigned HalfTicks = BitTicks / 2;
  localparam int unsigned CntW      = (BitTicks > 1) ? $clog2(BitTicks) : 1;
  localparam int unsigned BitLast   = (BitTicks > 0) ? BitTicks - 1 : 0;
  localparam int unsigned HalfLast  = (HalfTicks > 0) ? HalfTicks - 1 : 0;
  localparam int unsigned IdxW      = $clog2(DataWidth);

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state, state_n;
  logic [CntW-1:0]      cnt, cnt_n;
  logic [IdxW-1:0]      idx, idx_n;
  logic [DataWidth-1:0] shift, shift_n;
  logic [DataWidth-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_n;
  logic                 perr_n;
`endif

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .rx      (rx),
    .rx_sync (rx_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, sampling datapath and output pulse decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CntW'(HalfLast)) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      DATA: begin
        if (cnt == CntW'(BitLast)) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DataWidth-1:1]};
          if (idx == IdxW'(DataWidth - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + IdxW'(1);
          end
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CntW'(BitLast)) begin
          cnt_n     = '0;
          par_bit_n = rx_s;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == CntW'(BitLast)) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (!rx_s) begin
            ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift) != par_bit) begin
            perr_n = 1'b1;
`endif
          end else begin
            data_n  = shift;
            valid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath registers, edge-detect history and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      rx_prev    <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      frameError <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parityError <= 1'b0;
`endif
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      rx_prev    <= rx_s;
      data       <= data_n;
      valid      <= valid_n;
      frameError <= ferr_n;
      busy       <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      par_bit     <= par_bit_n;
      parityError <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx with a frame-level reference model.
// Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;

  localparam int unsigned ClkHz = 1000000;
  localparam int unsigned Baud  = 9600;
  localparam int unsigned BitT  = ClkHz / Baud;
  localparam int KindValid = 0;
  localparam int KindFerr  = 1;
  localparam int KindPerr  = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frameError;
  logic       busy;
  logic       perr_obs;
`ifdef UART_RX_PARITY_EN
  logic       parityError;
  assign perr_obs = parityError;
`else
  assign perr_obs = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_run = 0;
  int busy_max = 0;
  logic [7:0] last_good = 8'h00;
  ev_t got_q[$];
  ev_t exp_q[$];

  uart_rx #(.ClockFrequency(ClkHz), .BaudRate(Baud)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frameError (frameError),
`ifdef UART_RX_PARITY_EN
    .parityError(parityError),
`endif
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe pulses and busy run length away from the active edge.
  always @(negedge clock) begin : monitor
    ev_t e;
    if (reset === 1'b1) begin
      if (valid || frameError || perr_obs) begin
        e.kind = valid ? KindValid : (frameError ? KindFerr : KindPerr);
        e.d    = data;
        e.cyc  = cyc;
        got_q.push_back(e);
        check("pulse_exclusive", 32'(int'(valid) + int'(frameError) + int'(perr_obs)), 32'd1);
      end
      if (busy) begin
        busy_run++;
        if (busy_run > busy_max) busy_max = busy_run;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cycles(int'(BitT));
  endtask

  // Drive one frame and record what a correct receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    ev_t e;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (ParityOn) drive_bit(par);
    drive_bit(stop);
    e.cyc = 0;
    if (!stop) begin
      e.kind = KindFerr;
      e.d    = last_good;
    end else if (ParityOn && (par != ^b)) begin
      e.kind = KindPerr;
      e.d    = last_good;
    end else begin
      e.kind    = KindValid;
      e.d       = b;
      last_good = b;
    end
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_kind"}, 32'(got_q[i].kind), 32'(exp_q[i].kind));
      check({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : stim
    int start_cyc;
    int lat;
    logic prev_bad;
    logic [7:0] b;
    logic stop;
    logic par;
    int gap;

    rx    = 1'b1;
    reset = 1'b0;
    wait_cycles(4);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frameError), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_cycles(20);
    check("idle_busy", 32'(busy), 32'd0);

    // Single 0xA5 frame and its latency from the falling edge.
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_cycles(int'(BitT));
    lat = (got_q.size() > 0) ? (got_q[0].cyc - start_cyc) : -1;
    check("a5_latency_window", 32'(lat >= 986 && lat <= 994), 32'd1);
    compare_events("a5");

    // Short low glitch: aborted in START, no pulses.
    busy_max = 0;
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(2 * int'(BitT));
    check("glitch_busy_le54", 32'(busy_max <= 54), 32'd1);
    check("glitch_busy_seen", 32'(busy_max > 0), 32'd1);
    compare_events("glitch");

    // Bad stop bit, then line held low: no retrigger.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    busy_max = 0;
    rx = 1'b0;
    wait_cycles(3 * int'(BitT));
    check("hold_low_busy", 32'(busy_max), 32'd0);
    check("ferr_data_hold", 32'(data), 32'hA5);
    compare_events("badstop");
    rx = 1'b1;
    wait_cycles(int'(BitT));

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_cycles(int'(BitT));
    compare_events("b2b");

    // Reset during bit 4 of 0x55, then a clean 0x81.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    wait_cycles(int'(BitT) / 2);
    reset = 1'b0;
    wait_cycles(4);
    reset = 1'b1;
    last_good = 8'h00;
    wait_cycles(2 * int'(BitT));
    check("abort_data", 32'(data), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    compare_events("abort");
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_cycles(int'(BitT));
    compare_events("after_abort");

    if (ParityOn) begin
      send_frame(8'h07, 1'b1, 1'b0);
      wait_cycles(int'(BitT));
      send_frame(8'h07, 1'b1, 1'b1);
      wait_cycles(int'(BitT));
      compare_events("parity");
    end

    // Randomized frames with random gaps, bad stops and parity errors.
    prev_bad = 1'b0;
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 6) != 0);
      par  = (^b) ^ ($urandom_range(0, 3) == 0);
      gap  = prev_bad ? (20 + int'($urandom_range(0, 100))) : int'($urandom_range(0, 150));
      if (gap > 0) begin
        rx = 1'b1;
        wait_cycles(gap);
      end
      send_frame(b, stop, par);
      prev_bad = !stop;
      if (n % 6 == 5) begin
        rx = 1'b1;
        wait_cycles(int'(BitT));
        compare_events("rand");
        prev_bad = 1'b0;
      end
    end
    rx = 1'b1;
    wait_cycles(2 * int'(BitT));
    compare_events("rand_tail");
    check("final_data", 32'(data), 32'(last_good));
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter ClockFrequency, default 1000000, clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 9600, line bit rate in bit/s.
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data  output  8  last received byte.
REQ-007 SHALL have port valid  output  1  one-cycle pulse, byte in data is good.
REQ-008 SHALL have port frameError  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress, i.e. state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer, initialised high; all decisions use the synchronized value.
REQ-011 SHALL derive BitTicks = ClockFrequency/BaudRate and HalfTicks = BitTicks/2, both by integer division; defaults give 104 and 52.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP, plus PARITY when REQ-025 applies.
REQ-013 IDLE->START SHALL occur on a synchronized falling edge (previous 1, current 0); a line held low SHALL NOT retrigger.
REQ-014 START SHALL wait HalfTicks cycles, then resample: if low, go to DATA with the tick counter cleared; if high, treat it as a glitch and return to IDLE with no output pulse.
REQ-015 DATA SHALL sample 8 bits, LSB first, each exactly BitTicks cycles after the previous sample.
REQ-016 STOP SHALL sample BitTicks cycles after the last data or parity bit, then return to IDLE in the same transition.
REQ-017 If the stop sample is high, the byte SHALL be loaded into data and valid SHALL pulse on the next cycle.
REQ-018 If the stop sample is low, frameError SHALL pulse, data SHALL hold its previous value, and valid SHALL stay low.
REQ-019 valid and frameError SHALL never be high in the same cycle.
REQ-020 data SHALL change only on a valid pulse and SHALL hold its value otherwise.
REQ-021 Back-to-back frames SHALL be received with no idle gap: a falling edge seen in IDLE immediately after STOP SHALL start the next frame.
REQ-022 The tick counter SHALL be wide enough for BitTicks-1 and SHALL never wrap within a bit.

Reset
REQ-023 While reset is low at a clock edge, the block SHALL enter IDLE and set data=0x00, valid=0, frameError=0, busy=0, synchronizer flops=1, counters=0.
REQ-024 A reset applied mid-frame SHALL abort the frame with no pulse; reception SHALL resume on the first falling edge after reset is released.

Configuration
REQ-025 With UART_RX_PARITY_EN defined, SHALL add a PARITY state after DATA that samples one even-parity bit, and SHALL add port parityError (output, 1 bit).
REQ-026 With UART_RX_PARITY_EN defined, a parity mismatch with a good stop bit SHALL pulse parityError instead of valid, leave data unchanged, and never coincide with frameError; a bad stop bit SHALL pulse frameError only.
REQ-027 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, and the PARITY state and the parityError port SHALL not exist.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state enum type, the data width constant (8), and a function computing ticks per bit from ClockFrequency and BaudRate, shared with the transmitter.
REQ-029 The synchronizer SHALL be a separate sub-module, uart_rx_sync; all other logic SHALL stay in uart_rx.

Verification
REQ-030 Defaults, drive 0xA5 8N1 at 104 cycles/bit -> exactly one valid pulse with data=0xA5, about 9.5 bit times plus 2 cycles after the falling edge.
REQ-031 Drive rx low for 20 cycles, then high -> return to IDLE, no valid, no frameError, busy high for at most 54 cycles.
REQ-032 Drive 0x3C with the stop bit low -> one frameError pulse, no valid, data keeps its prior value; the line then held low causes no new frame until a fresh falling edge.
REQ-033 Drive 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses with data 0x00, then 0xFF.
REQ-034 Pull reset low during bit 4 of 0x55, then send 0x81 -> no pulse for the aborted frame, then valid with data=0x81; data reads 0x00 in between.
REQ-035 With UART_RX_PARITY_EN, send 0x07 with the parity bit set to 0 -> one parityError pulse, no valid; the same byte with parity 1 -> valid with data=0x07.
